// File: rtl/prog_counter_ras.sv
// ============================================================================
//  Module   : prog_counter_ras
//  Function : Fetch-stage program counter with relative jump, absolute load,
//             call/return through a circular return-address stack, and
//             vector-done redirect. Define PC_TRACE_EN to add last_pc/redirect.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module prog_counter_ras #(
    parameter int                  ADDR_MAX   = 16,
    parameter int                  OFFS_W     = 12,
    parameter int                  RAS_DEPTH  = 4,
    parameter logic [ADDR_MAX-1:0] VEC_ADDR   = 16'hFFF0,
    parameter logic [ADDR_MAX-1:0] RESET_ADDR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                jump,
    input  logic                call,
    input  logic                ret,
    input  logic                load,
    input  logic                v_done,
    input  logic [OFFS_W-1:0]   offset,
    input  logic [ADDR_MAX-1:0] load_addr,
    output logic [ADDR_MAX-1:0] pc,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_err
`ifdef PC_TRACE_EN
    ,
    output logic [ADDR_MAX-1:0] last_pc,
    output logic                redirect
`endif
);

    localparam int                  c_cnt_w    = $clog2(RAS_DEPTH + 1);
    localparam int                  c_ptr_w    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_full = c_cnt_w'(RAS_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_last = c_ptr_w'(RAS_DEPTH - 1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);
    localparam logic [ADDR_MAX-1:0] c_pc_one   = ADDR_MAX'(1);

    logic [ADDR_MAX-1:0] r_pc;
    logic [ADDR_MAX-1:0] r_stack [RAS_DEPTH];
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_err;

    logic [ADDR_MAX-1:0] w_offs_ext;
    logic [ADDR_MAX-1:0] w_pc_inc;
    logic [ADDR_MAX-1:0] w_pc_rel;
    logic [ADDR_MAX-1:0] w_pc_next;
    logic [ADDR_MAX-1:0] w_top;
    logic [c_ptr_w-1:0]  w_ptr_inc;
    logic [c_ptr_w-1:0]  w_ptr_dec;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_err;
    logic                w_redirect;

    assign w_offs_ext = ADDR_MAX'($signed(offset));
    assign w_pc_inc   = r_pc + c_pc_one;
    assign w_pc_rel   = r_pc + w_offs_ext;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_cnt_full);

    // r_wptr is the next push slot; the top of stack sits one slot behind it.
    assign w_ptr_inc  = (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_one;
    assign w_ptr_dec  = (r_wptr == '0) ? c_ptr_last : r_wptr - c_ptr_one;
    assign w_top      = r_stack[w_ptr_dec];

    always_comb begin
        w_pc_next  = w_pc_inc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_err      = 1'b0;
        w_redirect = 1'b1;
        if (v_done) begin
            w_pc_next = VEC_ADDR;
        end else if (load) begin
            w_pc_next = load_addr;
        end else if (ret) begin
            if (w_empty) begin
                w_err = 1'b1;
            end else begin
                w_pop     = 1'b1;
                w_pc_next = w_top;
            end
        end else if (call) begin
            w_push    = 1'b1;
            w_err     = w_full;
            w_pc_next = w_pc_rel;
        end else if (jump) begin
            w_pc_next = w_pc_rel;
        end else begin
            w_redirect = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_ADDR;
            r_wptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (enable) begin
            r_pc <= w_pc_next;
            if (w_push) begin
                // When full the push slot holds the oldest entry, so it is overwritten.
                r_stack[r_wptr] <= w_pc_inc;
                r_wptr          <= w_ptr_inc;
                if (!w_full) begin
                    r_count <= r_count + c_cnt_one;
                end
            end else if (w_pop) begin
                r_wptr  <= w_ptr_dec;
                r_count <= r_count - c_cnt_one;
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef PC_TRACE_EN
    logic [ADDR_MAX-1:0] r_last_pc;
    logic                r_redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_pc  <= '0;
            r_redirect <= 1'b0;
        end else begin
            r_redirect <= enable & w_redirect;
            if (enable) begin
                r_last_pc <= r_pc;
            end
        end
    end

    assign last_pc  = r_last_pc;
    assign redirect = r_redirect;
`endif

    assign pc        = r_pc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_counter_ras.sv
// ============================================================================
//  Module   : tb_prog_counter_ras
//  Function : Self-checking bench for prog_counter_ras against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_counter_ras;

    localparam int          DEPTH = 4;
    localparam logic [15:0] VEC   = 16'hFFF0;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable, jump, call, ret, load, v_done;
    logic [11:0] offset;
    logic [15:0] load_addr;
    logic [15:0] pc;
    logic        ras_empty, ras_full, ras_err;
`ifdef PC_TRACE_EN
    logic [15:0] last_pc;
    logic        redirect;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc, m_last;
    logic        m_err, m_redir;
    logic [15:0] m_ras [$];

    always #5 clock = ~clock;

    prog_counter_ras #(
        .ADDR_MAX   (16),
        .OFFS_W     (12),
        .RAS_DEPTH  (DEPTH),
        .VEC_ADDR   (VEC),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .load      (load),
        .v_done    (v_done),
        .offset    (offset),
        .load_addr (load_addr),
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
`ifdef PC_TRACE_EN
        ,
        .last_pc   (last_pc),
        .redirect  (redirect)
`endif
    );

    function automatic logic [15:0] sext(input logic [11:0] o);
        return {{4{o[11]}}, o};
    endfunction

    task automatic drive(input logic en, input logic j, input logic c, input logic r,
                         input logic l, input logic v, input logic [11:0] off,
                         input logic [15:0] la);
        enable = en; jump = j; call = c; ret = r; load = l; v_done = v;
        offset = off; load_addr = la;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_last = 16'h0000; m_err = 1'b0; m_redir = 1'b0;
        m_ras.delete();
    endtask

    // One clock edge: the model consumes the inputs held across the edge.
    task automatic tick();
        logic [15:0] npc;
        logic        redir;
        @(posedge clock);
        if (enable) begin
            redir = 1'b1;
            if (v_done)    npc = VEC;
            else if (load) npc = load_addr;
            else if (ret) begin
                if (m_ras.size() == 0) begin
                    npc   = m_pc + 16'd1;
                    m_err = 1'b1;
                end else begin
                    npc = m_ras.pop_back();
                end
            end else if (call) begin
                m_ras.push_back(m_pc + 16'd1);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                npc = m_pc + sext(offset);
            end else if (jump) npc = m_pc + sext(offset);
            else begin
                npc   = m_pc + 16'd1;
                redir = 1'b0;
            end
            m_last = m_pc;
            m_pc   = npc;
        end else begin
            redir = 1'b0;
        end
        m_redir = redir;
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0, 12'h000, 16'h0000);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 12'h000, 16'h0000);
        reset = 1'b1;
        #2;
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc); end
        n_checks++;
        if ({ras_empty, ras_full, ras_err} !== 3'b100) begin
            n_fail++; $display("FAIL reset_flags: got e/f/err=%b expected 100", {ras_empty, ras_full, ras_err});
        end
`ifdef PC_TRACE_EN
        n_checks++;
        if ({last_pc, redirect} !== 17'h0) begin
            n_fail++; $display("FAIL reset_trace: got last_pc=%h redirect=%b expected 0/0", last_pc, redirect);
        end
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_increment();
        drive(1, 0, 0, 0, 0, 0, 12'h000, 16'h0000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (pc !== 16'(i)) begin n_fail++; $display("FAIL incr_%0d: got %h expected %h", i, pc, 16'(i)); end
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL async_reset: got %h expected 0000", pc); end
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if (pc !== 16'h0001) begin n_fail++; $display("FAIL after_async_reset: got %h expected 0001", pc); end
    endtask

    task automatic test_jump();
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'h0010); tick();
        drive(1, 1, 0, 0, 0, 0, 12'hFF0, 16'h0000); tick();
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL jump_neg: got %h expected 0000", pc); end
        drive(1, 1, 0, 0, 0, 0, 12'h7FF, 16'h0000); tick();
        n_checks++;
        if (pc !== 16'h07FF) begin n_fail++; $display("FAIL jump_pos: got %h expected 07FF", pc); end
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'hFFFF); tick();
        drive(1, 0, 0, 0, 0, 0, 12'h000, 16'h0000); tick();
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL incr_wrap: got %h expected 0000", pc); end
        drive(1, 1, 0, 0, 0, 0, 12'hFFF, 16'h0000); tick();
        n_checks++;
        if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL jump_wrap: got %h expected FFFF", pc); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'h0100); tick();
        drive(1, 0, 1, 0, 0, 0, 12'h020, 16'h0000); tick();
        n_checks++;
        if ({pc, ras_empty} !== {16'h0120, 1'b0}) begin
            n_fail++; $display("FAIL call: got pc=%h empty=%b expected 0120/0", pc, ras_empty);
        end
        drive(1, 0, 0, 1, 0, 0, 12'h000, 16'h0000); tick();
        n_checks++;
        if ({pc, ras_empty} !== {16'h0101, 1'b1}) begin
            n_fail++; $display("FAIL ret: got pc=%h empty=%b expected 0101/1", pc, ras_empty);
        end
    endtask

    task automatic test_nested();
        logic [15:0] exp_ret [4];
        exp_ret = '{16'd51, 16'd41, 16'd31, 16'd21};
        apply_reset();
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'd10); tick();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 0, 0, 0, 12'd10, 16'h0000); tick();
            n_checks++;
            if ({pc, ras_full, ras_err} !== {16'(10 * (k + 2)), k >= 3, k == 4}) begin
                n_fail++;
                $display("FAIL nest_call_%0d: got pc=%h full=%b err=%b expected %h/%b/%b",
                         k, pc, ras_full, ras_err, 16'(10 * (k + 2)), k >= 3, k == 4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 0, 0, 12'h000, 16'h0000); tick();
            n_checks++;
            if (pc !== exp_ret[k]) begin n_fail++; $display("FAIL nest_ret_%0d: got %h expected %h", k, pc, exp_ret[k]); end
        end
        tick();
        n_checks++;
        if ({pc, ras_err, ras_empty} !== {16'd22, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL underflow: got pc=%h err=%b empty=%b expected 0016/1/1", pc, ras_err, ras_empty);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'h0200); tick();
        drive(1, 0, 1, 0, 0, 0, 12'h010, 16'h0000); tick();
        drive(1, 1, 1, 1, 1, 1, 12'h010, 16'h3333); tick();
        n_checks++;
        if ({pc, ras_empty, ras_full} !== {16'hFFF0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL prio_vdone: got pc=%h empty=%b full=%b expected FFF0/0/0", pc, ras_empty, ras_full);
        end
        drive(1, 1, 1, 1, 1, 0, 12'h010, 16'h4444); tick();
        n_checks++;
        if (pc !== 16'h4444) begin n_fail++; $display("FAIL prio_load: got %h expected 4444", pc); end
        drive(0, 1, 1, 1, 0, 0, 12'h005, 16'h0000); tick(); tick();
        n_checks++;
        if (pc !== 16'h4444) begin n_fail++; $display("FAIL hold: got %h expected 4444", pc); end
        drive(1, 0, 0, 1, 0, 0, 12'h000, 16'h0000); tick();
        n_checks++;
        if ({pc, ras_empty, ras_err} !== {16'h0201, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL prio_ras_kept: got pc=%h empty=%b err=%b expected 0201/1/0", pc, ras_empty, ras_err);
        end
    endtask

`ifdef PC_TRACE_EN
    task automatic test_trace();
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'h0005); tick();
        drive(1, 0, 0, 0, 1, 0, 12'h000, 16'h1234); tick();
        n_checks++;
        if ({last_pc, redirect} !== {16'h0005, 1'b1}) begin
            n_fail++; $display("FAIL trace_load: got last_pc=%h redirect=%b expected 0005/1", last_pc, redirect);
        end
        drive(1, 0, 0, 0, 0, 0, 12'h000, 16'h0000); tick();
        n_checks++;
        if ({last_pc, redirect, pc} !== {16'h1234, 1'b0, 16'h1235}) begin
            n_fail++; $display("FAIL trace_incr: got last_pc=%h redirect=%b pc=%h expected 1234/0/1235", last_pc, redirect, pc);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) apply_reset();
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
                  12'($urandom), 16'($urandom));
            tick();
            n_checks++;
            if (pc !== m_pc) begin n_fail++; $display("FAIL rand_pc_%0d: got %h expected %h", i, pc, m_pc); end
            n_checks++;
            if ({ras_empty, ras_full, ras_err} !== {m_ras.size() == 0, m_ras.size() == DEPTH, m_err}) begin
                n_fail++;
                $display("FAIL rand_flags_%0d: got e/f/err=%b%b%b expected %b%b%b", i, ras_empty, ras_full, ras_err,
                         m_ras.size() == 0, m_ras.size() == DEPTH, m_err);
            end
`ifdef PC_TRACE_EN
            n_checks++;
            if ({last_pc, redirect} !== {m_last, m_redir}) begin
                n_fail++; $display("FAIL rand_trace_%0d: got %h/%b expected %h/%b", i, last_pc, redirect, m_last, m_redir);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_async_reset();
        test_jump();
        test_back_to_back();
        test_nested();
        test_priority();
`ifdef PC_TRACE_EN
        test_trace();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
